p2s_rr_scheduler: RTL and testbench
===================================

// Module: p2s_rr_scheduler
// PURPOSE
//  Round-robin scheduler that shares one parallel-to-serial converter between NUM_REQ requesters.
//  Picks one pending requester and loads its word into the converter.
//  Waits for the converter to drain before arbitrating again.
//  Sits between the client blocks and the converter's parallel load interface.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..8)
//  DATA_W   4  width of a parallel word, equal to the converter's parallel_i width
// PORTS
//  clk          in   1                clock, rising edge
//  reset        in   1                asynchronous reset, active-low (0 = in reset)
//  req_i        in   NUM_REQ          per-requester request; held high until its gnt_o pulse
//  data_i       in   NUM_REQ*DATA_W   packed words; requester k owns bits [k*DATA_W +: DATA_W]
//  mask_i       in   NUM_REQ          1 = requester enabled; a masked req_i is ignored
//  gnt_o        out  NUM_REQ          one-hot, 1-cycle ack; the requester's word was loaded
//  conv_empty_i in   1                converter empty/ready flag
//  conv_load_o  out  1                1-cycle load strobe to the converter
//  conv_data_o  out  DATA_W           word presented to the converter's parallel_i
//  owner_o      out  $clog2(NUM_REQ)  index of the current transfer owner
//  busy_o       out  1                1 whenever state != IDLE
// BEHAVIOUR
//  Reset values (async, on reset=0, immediate):
//   - state=IDLE
//   - gnt_o=0, conv_load_o=0, conv_data_o=0, owner_o=0, busy_o=0
//   - round-robin pointer ptr=NUM_REQ-1, so requester 0 has first priority.
//  Converter contract:
//   - The converter captures conv_data_o on the rising edge where conv_load_o=1.
//   - conv_empty_i may stay high for at most 1 cycle after that edge, then stays low while shifting.
//   - conv_empty_i returns high when shifting is done.
//  eligible = req_i & mask_i.
//  Winner = first eligible index scanning ptr+1, ptr+2, ... modulo NUM_REQ.
//  FSM (all registered):
//   - IDLE: if |eligible && conv_empty_i, latch winner into owner_o and data_i[winner] into conv_data_o -> LOAD.
//     Otherwise stay in IDLE.
//   - LOAD (1 cycle): conv_load_o=1; gnt_o[owner_o]=1; ptr<=owner_o -> HOLD.
//   - HOLD (1 cycle): conv_empty_i ignored; covers the converter's empty-flag lag -> DRAIN.
//   - DRAIN: wait for conv_empty_i=1 -> IDLE.
//  Latency:
//   - Request seen in IDLE at edge N: conv_load_o/gnt_o high in cycle N+1.
//   - Earliest next load is after DRAIN exits.
//   - The converter is reloaded back-to-back with 1 idle cycle: DRAIN->IDLE->LOAD.
//  conv_data_o and owner_o hold their value from LOAD until the next IDLE->LOAD transition.
//  Boundary rules:
//   - conv_empty_i=0 in IDLE: no grant, requests stay pending; no starvation bookkeeping changes.
//   - req_i or mask_i change after the IDLE decision: the transfer completes with the latched word.
//     gnt_o still pulses for the latched owner.
//   - A requester that keeps req_i high after its gnt_o is treated as a new request.
//     It is scheduled only after all other eligible requesters (round-robin).
//   - Only one requester eligible: it is re-granted every transfer.
//   - ptr wraps from NUM_REQ-1 to 0.
//   - Reset mid-transfer (any state): all outputs go to reset values at once; the converter is not flushed.
//   - At most one bit of gnt_o is ever set; conv_load_o == |gnt_o at all times.
// TESTING (bench uses a behavioural converter model: 4-cycle drain, empty drops 1 cycle after load)
//  1. Single requester: req_i=0001, data0=4'b1101
//     -> one conv_load_o with conv_data_o=1101, gnt_o=0001, owner_o=0; busy_o high through DRAIN.
//  2. Simultaneous requests: req_i=0101 from reset, data0=4'hA, data2=4'h3
//     -> loads A (owner 0), then 3 (owner 2); gnt_o pulses 0001 then 0100.
//  3. Fairness: req_i=1111 held continuously
//     -> owner sequence 0,1,2,3,0,1; no requester granted twice before the others.
//  4. Busy converter: conv_empty_i forced 0 for 10 cycles with req_i=0010
//     -> no conv_load_o until empty=1, then load on the next cycle.
//  5. Masking: req_i=1001, mask_i=0111 -> only requester 0 granted; requester 3 never granted.
//  6. Reset in DRAIN: reset=0 for 2 cycles mid-transfer
//     -> busy_o=0, gnt_o=0 immediately; after release, requester 0 wins first.

Source files
------------

// File: rtl/p2s_rr_scheduler.sv
// rtl/p2s_rr_scheduler.sv - round-robin arbiter sharing one parallel-to-serial converter
// Grants one eligible requester per transfer, then waits for the converter to drain.
module p2s_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ*DATA_W-1:0]   data_i,
  input  logic [NUM_REQ-1:0]          mask_i,
  output logic [NUM_REQ-1:0]          gnt_o,
  input  logic                        conv_empty_i,
  output logic                        conv_load_o,
  output logic [DATA_W-1:0]           conv_data_o,
  output logic [$clog2(NUM_REQ)-1:0]  owner_o,
  output logic                        busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               load_q, load_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] eligible;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   idx;
  logic               found;
  logic [DATA_W-1:0]  words [NUM_REQ];

  assign eligible = req_i & mask_i;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_words
    assign words[k] = data_i[k*DATA_W +: DATA_W];
  end

  // Scan starts one past the last owner so the previous winner has lowest priority.
  always_comb begin
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    data_d  = data_q;
    gnt_d   = '0;
    load_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && conv_empty_i) begin
          owner_d       = winner;
          data_d        = words[winner];
          gnt_d[winner] = 1'b1;
          load_d        = 1'b1;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        ptr_d   = owner_q;
        state_d = HOLD;
      end
      HOLD:    state_d = DRAIN;
      DRAIN:   if (conv_empty_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      owner_q <= '0;
      data_q  <= '0;
      gnt_q   <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      gnt_q   <= gnt_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign conv_load_o = load_q;
  assign conv_data_o = data_q;
  assign owner_o     = owner_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_p2s_rr_scheduler.sv
// tb/tb_p2s_rr_scheduler.sv - scoreboard bench for p2s_rr_scheduler
// Behavioural converter: empty lags the load by one cycle, then drains for 4 cycles.
module tb_p2s_rr_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_i;
  logic [15:0] data_i;
  logic [3:0]  mask_i;
  logic [3:0]  gnt_o;
  logic        conv_empty_i;
  logic        conv_load_o;
  logic [3:0]  conv_data_o;
  logic [1:0]  owner_o;
  logic        busy_o;

  logic        force_busy;
  int          cnt = 0;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0] owner;
    logic [3:0] data;
  } exp_t;
  exp_t exp_q[$];

  p2s_rr_scheduler #(.NUM_REQ(4), .DATA_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_i        (req_i),
    .data_i       (data_i),
    .mask_i       (mask_i),
    .gnt_o        (gnt_o),
    .conv_empty_i (conv_empty_i),
    .conv_load_o  (conv_load_o),
    .conv_data_o  (conv_data_o),
    .owner_o      (owner_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (conv_load_o) cnt <= 5;
    else if (cnt != 0) cnt <= cnt - 1;
  end
  assign conv_empty_i = !force_busy && (cnt == 0 || cnt == 5);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int o, input logic [3:0] d);
    exp_t e;
    e.owner = 2'(o);
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_load(input string name, output int n);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (conv_load_o) begin
        n = i;
        break;
      end
    end
    if (n == 0) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy_o && conv_empty_i) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int n;
    exp_t e;
    reset      = 1'b0;
    req_i      = '0;
    mask_i     = 4'b1111;
    data_i     = 16'h0;
    force_busy = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (reset) begin
          if ($countones(gnt_o) > 1 || conv_load_o != |gnt_o)
            chk("gnt_invariant", {27'd0, conv_load_o, gnt_o}, {27'd0, |gnt_o, gnt_o});
          if (conv_load_o) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_load", {30'd0, owner_o}, 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              chk("gnt_o",       32'(gnt_o),       32'(4'b0001 << e.owner));
              chk("owner_o",     32'(owner_o),     32'(e.owner));
              chk("conv_data_o", 32'(conv_data_o), 32'(e.data));
            end
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk("rst_gnt",   32'(gnt_o), 32'd0);
    chk("rst_load",  32'(conv_load_o), 32'd0);
    chk("rst_data",  32'(conv_data_o), 32'd0);
    chk("rst_owner", 32'(owner_o), 32'd0);
    chk("rst_busy",  32'(busy_o), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1: single requester, load on the cycle after the decision
    data_i = 16'h000D;
    req_i  = 4'b0001;
    push(0, 4'b1101);
    wait_load("t1", n);
    chk("t1_latency", 32'(n), 32'd1);
    req_i = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_busy", 32'(busy_o), 32'd1);
      chk("t1_hold_data", 32'(conv_data_o), 32'hD);
    end
    wait_idle();

    // 2: simultaneous requests from reset
    do_reset();
    data_i = 16'h030A;
    req_i  = 4'b0101;
    push(0, 4'hA);
    push(2, 4'h3);
    wait_load("t2a", n);
    req_i[0] = 1'b0;
    wait_load("t2b", n);
    chk("t2_reload_gap", 32'(n), 32'd8);
    req_i[2] = 1'b0;
    wait_idle();

    // 3: fairness with all requesters held
    do_reset();
    data_i = 16'h7654;
    req_i  = 4'b1111;
    for (int k = 0; k < 6; k++) push(k % 4, 4'(4 + (k % 4)));
    for (int k = 0; k < 6; k++) wait_load("t3", n);
    req_i = 4'b0000;
    wait_idle();

    // 4: converter held busy, ptr now 1
    force_busy = 1'b1;
    data_i = 16'h00E0;
    req_i  = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_no_load", 32'(conv_load_o), 32'd0);
    end
    push(1, 4'hE);
    force_busy = 1'b0;
    wait_load("t4", n);
    chk("t4_latency", 32'(n), 32'd1);
    req_i = 4'b0000;
    wait_idle();

    // 5: masked requester 3 never granted; requester 0 re-granted
    data_i = 16'h9005;
    mask_i = 4'b0111;
    req_i  = 4'b1001;
    push(0, 4'h5);
    push(0, 4'h5);
    wait_load("t5a", n);
    wait_load("t5b", n);
    req_i = 4'b1000;
    repeat (20) @(negedge clk);
    chk("t5_masked_idle", 32'(busy_o), 32'd0);
    mask_i = 4'b1111;
    req_i  = 4'b0000;
    wait_idle();

    // 6: reset during DRAIN, ptr now 0 so requester 2 wins
    data_i = 16'h0B0C;
    req_i  = 4'b0100;
    push(2, 4'hB);
    wait_load("t6", n);
    req_i = 4'b0000;
    repeat (2) @(negedge clk);
    chk("t6_in_drain", 32'(busy_o), 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_rst_busy",  32'(busy_o), 32'd0);
    chk("t6_rst_gnt",   32'(gnt_o), 32'd0);
    chk("t6_rst_owner", 32'(owner_o), 32'd0);
    chk("t6_rst_data",  32'(conv_data_o), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    req_i = 4'b0101;
    push(0, 4'hC);
    push(2, 4'hB);
    wait_load("t6a", n);
    req_i[0] = 1'b0;
    wait_load("t6b", n);
    req_i[2] = 1'b0;
    wait_idle();

    @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
